jpeg_rle_decoder: RTL

JPEG_RLE_DECODER -- requirements
Module: jpeg_rle_decoder

---
 rtl/jpeg_dec_pkg.sv | 23 ++
 rtl/jpeg_amp_decode.sv | 23 ++
 rtl/jpeg_rle_decoder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/jpeg_dec_pkg.sv
// Shared types and constants for the JPEG run-length coefficient decoder.
package jpeg_dec_pkg;

    localparam int unsigned COEF_W_DEF = 12;
    localparam int unsigned AMP_W      = 12;

    localparam logic [3:0] DC_MAX_SIZE = 4'd11;
    localparam logic [3:0] AC_MAX_SIZE = 4'd10;

    localparam logic [3:0] EOB_RUN  = 4'd0;
    localparam logic [3:0] EOB_SIZE = 4'd0;
    localparam logic [3:0] ZRL_RUN  = 4'd15;
    localparam logic [3:0] ZRL_SIZE = 4'd0;

    typedef enum logic [2:0] {
        S_DC,
        S_AC,
        S_ZERO,
        S_VAL,
        S_FILL
    } dec_state_t;

endpackage

// File: rtl/jpeg_amp_decode.sv
// JPEG amplitude extension: turns (category, raw bits) into a signed value.
module jpeg_amp_decode
    import jpeg_dec_pkg::*;
(
    input  logic [3:0]              size,
    input  logic [10:0]             bits,
    output logic signed [AMP_W-1:0] value
);

    logic [AMP_W-1:0] span;
    logic [AMP_W-1:0] mag;

    // Top bit of the category set means positive; otherwise value = bits - (2^size - 1).
    always_comb begin
        span  = (AMP_W'(1) << size) - AMP_W'(1);
        mag   = {1'b0, bits} & span;
        value = '0;
        if (size != 4'd0 && size <= DC_MAX_SIZE) begin
            value = (mag > (span >> 1)) ? signed'(mag) : signed'(mag - span);
        end
    end

endmodule

// File: rtl/jpeg_rle_decoder.sv
// Expands DC/AC run-length symbols into 64 zigzag-ordered coefficients per block.
module jpeg_rle_decoder
    import jpeg_dec_pkg::*;
#(
    parameter int unsigned COEF_W = COEF_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     restart_i,
    input  logic                     sym_valid,
    output logic                     sym_ready,
    input  logic [3:0]               sym_run,
    input  logic [3:0]               sym_size,
    input  logic [10:0]              sym_bits,
    output logic                     coef_valid,
    input  logic                     coef_ready,
    output logic signed [COEF_W-1:0] coef_data,
    output logic [5:0]               coef_index,
    output logic                     coef_last,
    output logic                     err
);

    dec_state_t state, state_nxt;

    logic [5:0]               next_idx;
    logic [3:0]               zero_cnt;
    logic signed [COEF_W-1:0] pred;
    logic signed [COEF_W-1:0] pend;
    logic signed [AMP_W-1:0]  amp_val;
    logic signed [COEF_W-1:0] amp_ext;
    logic signed [COEF_W-1:0] ac_value;
    logic [3:0]               amp_size;
    logic [6:0]               run_end;
    logic                     size_ok;
    logic                     is_eob;
    logic                     is_zrl;
    logic                     overflow;
    logic                     advance;
    logic                     accept;
    logic                     at_last;
    logic                     emit;
    logic                     err_set;
    logic [5:0]               emit_idx;
    logic signed [COEF_W-1:0] emit_data;

    assign advance  = !coef_valid || coef_ready;
    assign accept   = sym_valid && sym_ready;
    assign size_ok  = (state == S_DC) ? (sym_size <= DC_MAX_SIZE) : (sym_size <= AC_MAX_SIZE);
    assign amp_size = size_ok ? sym_size : 4'd0;
    assign amp_ext  = COEF_W'(amp_val);
    assign is_eob   = (sym_run == EOB_RUN) && (sym_size == EOB_SIZE);
    assign is_zrl   = (sym_run == ZRL_RUN) && (sym_size == ZRL_SIZE);
    assign ac_value = is_zrl ? '0 : amp_ext;
    assign run_end  = {1'b0, next_idx} + {3'b000, sym_run};
    assign overflow = !is_eob && (run_end > 7'd63);
    assign at_last  = (next_idx == 6'd63);

    jpeg_amp_decode u_amp (
        .size  (amp_size),
        .bits  (sym_bits),
        .value (amp_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_DC;
        end else begin
            state <= state_nxt;
        end
    end

    // ZRL is handled as run 15 followed by a zero value, i.e. 16 zeros.
    always_comb begin
        state_nxt = state;
        case (state)
            S_DC: if (accept) state_nxt = S_AC;
            S_AC: begin
                if (accept) begin
                    if (is_eob || overflow)     state_nxt = at_last ? S_DC : S_FILL;
                    else if (sym_run == 4'd0)   state_nxt = at_last ? S_DC : S_AC;
                    else if (sym_run == 4'd1)   state_nxt = S_VAL;
                    else                        state_nxt = S_ZERO;
                end
            end
            S_ZERO: if (advance && zero_cnt == 4'd1) state_nxt = S_VAL;
            S_VAL:  if (advance) state_nxt = at_last ? S_DC : S_AC;
            S_FILL: if (advance && at_last) state_nxt = S_DC;
            default: state_nxt = S_DC;
        endcase
        if (restart_i) state_nxt = S_DC;
    end

    always_comb begin
        sym_ready = !rst && !restart_i && advance && (state == S_DC || state == S_AC);
    end

    // The first coefficient of an accepted symbol is produced in the accept cycle itself.
    always_comb begin
        emit      = 1'b0;
        emit_idx  = next_idx;
        emit_data = '0;
        err_set   = 1'b0;
        case (state)
            S_DC: begin
                emit      = accept;
                emit_idx  = '0;
                emit_data = pred + amp_ext;
                err_set   = accept && !size_ok;
            end
            S_AC: begin
                emit      = accept;
                emit_data = (is_eob || overflow || sym_run != 4'd0) ? '0 : ac_value;
                err_set   = accept && (!size_ok || overflow);
            end
            S_ZERO, S_FILL: emit = advance;
            S_VAL: begin
                emit      = advance;
                emit_data = pend;
            end
            default: emit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coef_valid <= 1'b0;
            coef_data  <= '0;
            coef_index <= '0;
            coef_last  <= 1'b0;
            err        <= 1'b0;
            next_idx   <= '0;
            zero_cnt   <= '0;
            pred       <= '0;
            pend       <= '0;
        end else if (restart_i) begin
            coef_valid <= 1'b0;
            next_idx   <= '0;
            pred       <= '0;
        end else begin
            if (advance) begin
                coef_valid <= emit;
                if (emit) begin
                    coef_data  <= emit_data;
                    coef_index <= emit_idx;
                    coef_last  <= (emit_idx == 6'd63);
                    next_idx   <= emit_idx + 6'd1;
                end
            end
            if (accept && state == S_DC) pred <= emit_data;
            if (accept && state == S_AC) begin
                zero_cnt <= sym_run - 4'd1;
                pend     <= ac_value;
            end
            if (state == S_ZERO && advance) zero_cnt <= zero_cnt - 4'd1;
            if (err_set) err <= 1'b1;
        end
    end

endmodule
